// File: rtl/labs_seq_gen.sv
// labs_seq_gen: enumerates LABS candidate sequences first..last (inclusive) on a valid/ready stream.
// Define LABS_SEQ_GEN_GRAY_EN to present the internal counter Gray-coded on o_seq.
module labs_seq_gen #(
    parameter int SEQ_WIDTH = 30,
    parameter int LEN_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic [LEN_WIDTH-1:0] i_offset,
    input  logic [SEQ_WIDTH-1:0] i_first,
    input  logic [SEQ_WIDTH-1:0] i_last,
    input  logic                 i_ready,
    output logic [SEQ_WIDTH-1:0] o_seq,
    output logic [SEQ_WIDTH-1:0] o_mask,
    output logic [LEN_WIDTH-1:0] o_offset,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SEQ_WIDTH:0]   o_count
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    localparam logic [LEN_WIDTH-1:0] SW = LEN_WIDTH'(SEQ_WIDTH);
    state_t               state_q, state_d;
    logic [SEQ_WIDTH-1:0] cnt_q, cnt_d, last_q, last_d, mask_q, mask_d;
    logic [LEN_WIDTH-1:0] offset_q, offset_d, len;
    logic [SEQ_WIDTH:0]   count_q, count_d;
    logic                 hs, at_last;
    assign len     = (i_len == '0 || i_len > SW) ? SW : i_len;
    assign hs      = state_q == RUN && i_ready;
    assign at_last = cnt_q == last_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        mask_d   = mask_q;
        offset_d = offset_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (i_start) begin
                mask_d   = {SEQ_WIDTH{1'b1}} >> (SW - len);
                offset_d = i_offset;
                cnt_d    = i_first & mask_d;
                last_d   = i_last & mask_d;
                count_d  = '0;
                state_d  = cnt_d > last_d ? FLUSH : RUN;
            end
            RUN: begin
                // Stop on equality with last, so last = 2^N-1 never wraps to 0
                count_d = hs ? count_q + 1'b1 : count_q;
                cnt_d   = hs && !at_last ? cnt_q + 1'b1 : cnt_q;
                state_d = i_abort || (hs && at_last) ? FLUSH : RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            mask_q   <= '0;
            offset_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            mask_q   <= mask_d;
            offset_q <= offset_d;
            count_q  <= count_d;
        end
    end
`ifdef LABS_SEQ_GEN_GRAY_EN
    assign o_seq = cnt_q ^ (cnt_q >> 1);
`else
    assign o_seq = cnt_q;
`endif
    assign o_mask   = mask_q;
    assign o_offset = offset_q;
    assign o_valid  = state_q == RUN;
    assign o_busy   = state_q == RUN;
    assign o_done   = state_q == FLUSH;
    assign o_count  = count_q;
endmodule

// File: tb/tb_labs_seq_gen.sv
// tb_labs_seq_gen: table-driven and randomized runs of labs_seq_gen against an enumerating model.
module tb_labs_seq_gen;
    logic        clk = 0, rst = 1, i_start = 0, i_abort = 0, i_ready = 0;
    logic [6:0]  i_len = 0, i_offset = 0;
    logic [29:0] i_first = 0, i_last = 0;
    logic [29:0] o_seq, o_mask;
    logic [6:0]  o_offset;
    logic        o_valid, o_busy, o_done;
    logic [30:0] o_count;
    int vectors = 0, miscompares = 0;

    labs_seq_gen dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_len(i_len),
        .i_offset(i_offset), .i_first(i_first), .i_last(i_last), .i_ready(i_ready),
        .o_seq(o_seq), .o_mask(o_mask), .o_offset(o_offset), .o_valid(o_valid),
        .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        int          off;
        logic [29:0] first;
        logic [29:0] last;
        int          rmode;
        int          abort_at;
        bit          abort_rdy;
        bit          sab;
        bit          restart;
        int          exp_count;
        logic [29:0] exp_mask;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask_of(input int len);
        int n;
        n = (len < 1 || len > 30) ? 30 : len;
        return (64'd1 << n) - 1;
    endfunction

    task automatic run(input vec_t v, input int exp_count, input logic [63:0] exp_mask);
        logic [63:0] q[$];
        logic [63:0] m, f, l;
        int idx, cyc;
        bit r, ab;
        m = mask_of(v.len);
        f = 64'(v.first) & m;
        l = 64'(v.last) & m;
        q = {};
        if (f <= l)
            for (logic [63:0] c = f; c <= l; c++)
`ifdef LABS_SEQ_GEN_GRAY_EN
                q.push_back(c ^ (c >> 1));
`else
                q.push_back(c);
`endif
        i_len = 7'(v.len); i_offset = 7'(v.off); i_first = v.first; i_last = v.last;
        i_start = 1; i_abort = v.sab; i_ready = 0;
        @(negedge clk);
        i_start = 0; i_abort = 0;
        chk("busy_after_start", 64'(o_busy), 64'(q.size() > 0));
        idx = 0; cyc = 0;
        while (o_valid && cyc < 1000) begin
            if (idx >= q.size()) begin
                chk("extra_beat", 64'(idx), 64'(q.size()));
                break;
            end
            chk("seq", 64'(o_seq), q[idx]);
            chk("mask", 64'(o_mask), exp_mask);
            chk("offset", 64'(o_offset), 64'(v.off));
            chk("count_live", 64'(o_count), 64'(idx));
            r  = v.rmode == 0 ? 1'b1 : v.rmode == 1 ? (cyc % 3 == 0) : 1'($urandom);
            ab = v.abort_at >= 0 && idx == v.abort_at;
            if (ab) r = v.abort_rdy;
            i_ready = r; i_abort = ab;
            i_start = v.restart && cyc == 1;
            i_len = 7'($urandom); i_offset = 7'($urandom);
            i_first = 30'($urandom); i_last = 30'($urandom);
            if (r) idx++;
            cyc++;
            @(negedge clk);
            i_abort = 0; i_start = 0;
        end
        chk("no_timeout", 64'(cyc < 1000), 64'd1);
        chk("beats", 64'(idx), 64'(exp_count));
        chk("done_pulse", 64'(o_done), 64'd1);
        chk("valid_end", 64'(o_valid), 64'd0);
        chk("busy_end", 64'(o_busy), 64'd0);
        chk("count_end", 64'(o_count), 64'(exp_count));
        i_ready = 0;
        @(negedge clk);
        chk("done_clear", 64'(o_done), 64'd0);
        chk("count_hold", 64'(o_count), 64'(exp_count));
        chk("idle_busy", 64'(o_busy), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_seq"}, 64'(o_seq), 64'd0);
        chk({tag, "_mask"}, 64'(o_mask), 64'd0);
        chk({tag, "_offset"}, 64'(o_offset), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_count"}, 64'(o_count), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{20, 10, 30'h0BEEF, 30'h0BEF2, 0, -1, 0, 0, 0, 4, 30'hFFFFF};
        tbl[1]  = '{20, 10, 30'h0BEEF, 30'h0BEF2, 1, -1, 0, 0, 1, 4, 30'hFFFFF};
        tbl[2]  = '{4, 0, 30'hE, 30'hF, 0, -1, 0, 0, 0, 2, 30'hF};
        tbl[3]  = '{8, 3, 30'h5, 30'h3, 0, -1, 0, 0, 0, 0, 30'hFF};
        tbl[4]  = '{10, 7, 30'h0, 30'd99, 0, 2, 0, 0, 0, 2, 30'h3FF};
        tbl[5]  = '{10, 7, 30'h0, 30'd99, 1, 2, 1, 0, 0, 3, 30'h3FF};
        tbl[6]  = '{0, 1, 30'h3FFFFFFD, 30'h3FFFFFFF, 0, -1, 0, 1, 0, 3, 30'h3FFFFFFF};
        tbl[7]  = '{40, 2, 30'h5, 30'h6, 2, -1, 0, 0, 0, 2, 30'h3FFFFFFF};
        tbl[8]  = '{4, 5, 30'h1F3, 30'h1F5, 1, -1, 0, 0, 0, 3, 30'hF};
        tbl[9]  = '{3, 0, 30'h0, 30'h7, 0, -1, 0, 0, 0, 8, 30'h7};
        tbl[10] = '{1, 0, 30'h0, 30'h1, 1, -1, 0, 0, 1, 2, 30'h1};

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 0;
        @(negedge clk);

        i_abort = 1;
        @(negedge clk);
        i_abort = 0;
        chk("idle_abort_busy", 64'(o_busy), 64'd0);
        chk("idle_abort_done", 64'(o_done), 64'd0);
        chk("idle_abort_valid", 64'(o_valid), 64'd0);

        for (int i = 0; i < 11; i++) run(tbl[i], tbl[i].exp_count, 64'(tbl[i].exp_mask));

        i_len = 8; i_offset = 9; i_first = 0; i_last = 50; i_start = 1; i_ready = 1;
        @(negedge clk);
        i_start = 0;
        repeat (3) @(negedge clk);
        chk("mid_valid", 64'(o_valid), 64'd1);
        chk("mid_count", 64'(o_count), 64'd3);
        rst = 1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 0; i_ready = 0;
        @(negedge clk);
        chk("post_rst_valid", 64'(o_valid), 64'd0);
        chk("post_rst_done", 64'(o_done), 64'd0);

        for (int k = 0; k < 25; k++) begin
            vec_t v;
            logic [63:0] m, f, l;
            int nb, ec;
            v.len = $urandom_range(0, 34);
            v.off = $urandom_range(0, 127);
            m = mask_of(v.len);
            v.first = 30'($urandom);
            f = 64'(v.first) & m;
            v.last = 30'(f + 64'($urandom_range(0, 15))) ^ (30'($urandom) & ~30'(m));
            if ($urandom % 6 == 0) v.last = v.first - 30'd1;
            l = 64'(v.last) & m;
            nb = f > l ? 0 : int'(l - f + 1);
            v.rmode = 2;
            v.abort_at = ($urandom % 3 == 0) ? $urandom_range(0, 15) : -1;
            v.abort_rdy = 1'($urandom);
            v.sab = 1'($urandom);
            v.restart = 1'($urandom);
            ec = (v.abort_at >= 0 && v.abort_at < nb) ? v.abort_at + int'(v.abort_rdy) : nb;
            v.exp_count = ec;
            v.exp_mask = 30'(m);
            run(v, ec, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/labs_seq_gen.md
Name: labs_seq_gen

Overview:
- Sequence source for the LABS energy pipeline.
- Enumerates candidate binary sequences over a programmed inclusive range and presents each one, with its length mask and offset, on a valid/ready stream.
- The stream drives the energy-calculation buffer's i_seq/i_mask/i_offset/i_valid inputs and honours that block's o_ready as backpressure.
- Sits between the host/config logic and the energy calculator.

Parameters:
- SEQ_WIDTH, 30: max sequence length; width of sequence and mask.
- LEN_WIDTH, 7: width of length and offset fields.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  pulse; latches config and begins a run (ignored while busy)
- i_abort  in  1  stop the current run at the next cycle
- i_len  in  LEN_WIDTH  sequence length N, valid 1..SEQ_WIDTH
- i_offset  in  LEN_WIDTH  offset forwarded unchanged on every beat
- i_first  in  SEQ_WIDTH  first sequence value (low N bits used)
- i_last  in  SEQ_WIDTH  last sequence value, inclusive (low N bits used)
- i_ready  in  1  downstream ready
- o_seq  out  SEQ_WIDTH  candidate sequence; bits >= N are zero
- o_mask  out  SEQ_WIDTH  (1<<N)-1
- o_offset  out  LEN_WIDTH  latched i_offset
- o_valid  out  1  beat valid
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse at end of run
- o_count  out  SEQ_WIDTH+1  beats accepted in current/last run

Behaviour:
- Reset values: o_seq=0, o_mask=0, o_offset=0, o_valid=0, o_busy=0, o_done=0, o_count=0; FSM in IDLE.
- A synchronous reset asserted mid-run returns the block to IDLE immediately; o_valid is 0 on the next cycle and the in-flight beat is dropped.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - On i_start: latch N, offset, first&mask and last&mask; clear o_count.
  - If first > last (after masking): go to FLUSH; o_done pulses next cycle; zero beats.
  - Otherwise: go to RUN; o_valid=1 and o_seq=first in the cycle after i_start.
- RUN:
  - Handshake occurs when o_valid && i_ready. o_count increments by 1 per handshake.
  - On a handshake with o_seq != last: o_seq advances by 1 in the same clock edge, giving 1 beat/cycle when i_ready is held high.
  - On a handshake with o_seq == last: o_valid drops and the FSM goes to FLUSH.
  - The compare is equality, never overflow. last = 2^N-1 must terminate cleanly with no wrap to 0.
  - While o_valid && !i_ready: o_seq, o_mask, o_offset and o_valid hold stable. o_valid never deasserts without a handshake, except on abort or reset.
- FLUSH: o_done=1 for exactly one cycle, o_busy=0, then IDLE.
- i_abort in RUN:
  - Next cycle o_valid=0, go to FLUSH.
  - A handshake in the abort cycle is still counted.
  - i_abort in IDLE or FLUSH has no effect.
- Simultaneous i_start and i_abort in IDLE: start wins, abort ignored.
- i_start while busy is ignored; latched config is unchanged.
- o_busy=1 in RUN (and in FLUSH only until o_done), 0 in IDLE.
- N outside 1..SEQ_WIDTH: clamp to SEQ_WIDTH.
- o_mask is computed from the latched N, never from the live input.

Optional Feature:
- Macro: LABS_SEQ_GEN_GRAY_EN.
- Defined:
  - o_seq = cnt ^ (cnt>>1) of the internal counter, where the counter runs first..last as above.
  - Consecutive beats differ in one bit, for incremental energy evaluation downstream.
  - Termination compares the counter, not o_seq.
- Undefined: o_seq equals the counter (plain binary).

Test Plan:
- N=20, offset=10, first=0x0BEEF, last=0x0BEF2, i_ready=1 -> o_seq 0x0BEEF,0x0BEF0,0x0BEF1,0x0BEF2 on 4 consecutive cycles, starting the cycle after i_start; o_mask=0xFFFFF, o_offset=10; o_done pulses the cycle after the last beat; o_count=4.
- Same run with i_ready toggling 1,0,0,1,... -> o_seq held stable across every stall; no beat lost or duplicated; o_count=4.
- N=4, first=0xE, last=0xF -> beats 0xE,0xF then done; no 0x0 beat; o_count=2.
- first=5, last=3 -> no o_valid; o_done pulse; o_count=0.
- i_abort after 2 handshakes of a 100-beat run; rst mid-run in a separate run -> abort: o_count=2, o_done pulses, busy clears; reset: all outputs at reset values next cycle.
- With LABS_SEQ_GEN_GRAY_EN, N=3, first=0, last=7 -> o_seq 0,1,3,2,6,7,5,4.
